cert_ledger: RTL and testbench

Downstream consumer of the Logic Engine Interface certificate port. Captures every `cert_write` pulse (address + hash) into a small FIFO and drains it over a valid/ready link to off-chip certificate storage. Folds accepted hashes into a running ledger digest, and supports a counted flush that seals the digest at a known point. The LEI has no backpressure, so this block never stalls its producer; it drops and flags instead.

---
 rtl/cert_ledger_pkg.sv | 13 +
 rtl/cert_ledger_fifo.sv | 33 +++
 rtl/cert_ledger.sv | 93 +++++++++
 tb/tb_cert_ledger.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cert_ledger_pkg.sv
// cert_ledger_pkg: shared state encoding, widths and digest fold (THIELE_CERT_CHAIN_EN selects chained fold)
package thiele_cert_pkg;
  localparam int DATA_W = 32;
  localparam int CERT_ROT = 5;
  typedef enum logic [2:0] {RUN = 3'd0, FLUSH = 3'd1, SEAL = 3'd2} state_t;
  function automatic logic [DATA_W-1:0] cert_fold(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] data, input logic [7:0] addr);
`ifdef THIELE_CERT_CHAIN_EN
    return {d[DATA_W-1-CERT_ROT:0], d[DATA_W-1:DATA_W-CERT_ROT]} ^ data ^ {{(DATA_W-8){1'b0}}, addr};
`else
    return d ^ data ^ {DATA_W{1'b0 & addr[0]}};
`endif
  endfunction
endpackage

// File: rtl/cert_ledger_fifo.sv
// cert_fifo: synchronous first-word-fall-through FIFO of {addr, data} entries with occupancy count
module cert_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [63:0]              wdata,
  input  logic                     pop,
  output logic [63:0]              rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   occ
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign valid = occ != '0;
  assign rdata = valid ? mem[rp] : '0;
  // storage array, written only on accepted pushes
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  // pointers wrap naturally modulo DEPTH; the extra count bit separates full from empty
  always_ff @(posedge clk)
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/cert_ledger.sv
// cert_ledger: captures LEI certificate writes, drains them, keeps a folded digest and a counted flush/seal (THIELE_CERT_CHAIN_EN)
module cert_ledger
  import thiele_cert_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cert_write,
  input  logic [31:0]       cert_addr,
  input  logic [31:0]       cert_data,
  output logic              drain_valid,
  output logic [31:0]       drain_addr,
  output logic [31:0]       drain_data,
  input  logic              drain_ready,
  input  logic              flush_req,
  output logic              flush_done,
  input  logic              clear,
  output logic [31:0]       digest,
  output logic [31:0]       sealed_digest,
  output logic [CNT_W-1:0]  accepted_cnt,
  output logic [CNT_W-1:0]  dropped_cnt,
  output logic              overflow,
  output logic [31:0]       ledger_status
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [AW:0] occ, left, left_nx;
  logic [63:0] head;
  logic full, hs, accept, drop;
  logic [DATA_W-1:0] dig_base, dig_nx;
  logic [CNT_W-1:0] acc_base, drop_base;
  state_t state, state_nx;
  assign full   = occ == FULL;
  assign hs     = drain_valid && drain_ready;
  assign accept = cert_write && !full;
  assign drop   = cert_write && full;
  assign {drain_addr, drain_data} = head;
  assign ledger_status = {16'h0, 8'(occ), 5'h0, state};
  cert_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata ({cert_addr, cert_data}),
    .pop   (hs),
    .rdata (head),
    .valid (drain_valid),
    .occ   (occ)
  );
  // clear takes effect before this cycle's fold and count, so a colliding write starts from zero
  always_comb begin
    dig_base  = clear ? '0 : digest;
    dig_nx    = accept ? cert_fold(dig_base, cert_data, cert_addr[7:0]) : dig_base;
    acc_base  = clear ? '0 : accepted_cnt;
    drop_base = clear ? '0 : dropped_cnt;
  end
  // flush sequencing: only entries queued at the request are counted down
  always_comb begin
    state_nx = state;
    left_nx  = left;
    if (state == RUN && flush_req) begin
      left_nx  = occ;
      state_nx = occ == '0 ? SEAL : FLUSH;
    end else if (state == FLUSH && hs) begin
      left_nx  = left - 1'b1;
      state_nx = left == (AW+1)'(1) ? SEAL : FLUSH;
    end else if (state == SEAL) begin
      state_nx = RUN;
    end
  end
  // ledger registers; the seal captures the post-fold digest of the SEAL cycle
  always_ff @(posedge clk)
    if (rst) begin
      state         <= RUN;
      left          <= '0;
      digest        <= '0;
      sealed_digest <= '0;
      accepted_cnt  <= '0;
      dropped_cnt   <= '0;
      overflow      <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      state         <= state_nx;
      left          <= left_nx;
      digest        <= dig_nx;
      sealed_digest <= state == SEAL ? dig_nx : sealed_digest;
      accepted_cnt  <= accept && !(&acc_base) ? acc_base + 1'b1 : acc_base;
      dropped_cnt   <= drop && !(&drop_base) ? drop_base + 1'b1 : drop_base;
      overflow      <= (overflow && !clear) || drop;
      flush_done    <= state == SEAL;
    end
endmodule

// File: tb/tb_cert_ledger.sv
// tb_cert_ledger: directed, table-driven and randomized checks of cert_ledger against a queue-based model
module tb_cert_ledger;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic cert_write = 1'b0, drain_ready = 1'b0, flush_req = 1'b0, clear = 1'b0;
  logic [31:0] cert_addr = '0, cert_data = '0;
  logic drain_valid, flush_done, overflow;
  logic [31:0] drain_addr, drain_data, digest, sealed_digest, ledger_status;
  logic [CNT_W-1:0] accepted_cnt, dropped_cnt;
  always #5 clk = ~clk;
  cert_ledger #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cert_write(cert_write), .cert_addr(cert_addr), .cert_data(cert_data),
    .drain_valid(drain_valid), .drain_addr(drain_addr), .drain_data(drain_data), .drain_ready(drain_ready),
    .flush_req(flush_req), .flush_done(flush_done), .clear(clear), .digest(digest),
    .sealed_digest(sealed_digest), .accepted_cnt(accepted_cnt), .dropped_cnt(dropped_cnt),
    .overflow(overflow), .ledger_status(ledger_status)
  );
  logic [63:0] q[$];
  logic [31:0] m_dig = '0, m_seal = '0;
  logic [CNT_W-1:0] m_acc = '0, m_drop = '0;
  logic m_ovf = 1'b0, m_done = 1'b0;
  int m_phase = 0, m_left = 0;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [7:0] addr; logic [31:0] data; logic [31:0] exp;} vec_t;
  vec_t vecs[4];
  function automatic logic [31:0] ref_fold(input logic [31:0] d, input logic [31:0] data, input logic [7:0] addr);
`ifdef THIELE_CERT_CHAIN_EN
    return ((d << 5) | (d >> 27)) ^ data ^ {24'h0, addr};
`else
    return d ^ data;
`endif
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_all();
    logic [63:0] h;
    h = q.size() > 0 ? q[0] : 64'h0;
    chk("drain_valid", 32'(drain_valid), 32'(q.size() > 0));
    chk("drain_addr", drain_addr, h[63:32]);
    chk("drain_data", drain_data, h[31:0]);
    chk("digest", digest, m_dig);
    chk("sealed_digest", sealed_digest, m_seal);
    chk("accepted_cnt", 32'(accepted_cnt), 32'(m_acc));
    chk("dropped_cnt", 32'(dropped_cnt), 32'(m_drop));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("flush_done", 32'(flush_done), 32'(m_done));
    chk("ledger_status", ledger_status, {16'h0, 8'(q.size()), 5'h0, 3'(m_phase)});
  endtask
  task automatic model_tick();
    int sz;
    bit hs, acc;
    if (rst) begin
      q.delete();
      m_dig = '0; m_seal = '0; m_acc = '0; m_drop = '0;
      m_ovf = 1'b0; m_done = 1'b0; m_phase = 0; m_left = 0;
      return;
    end
    sz  = q.size();
    hs  = sz > 0 && drain_ready;
    acc = cert_write && sz < DEPTH;
    if (hs) void'(q.pop_front());
    if (acc) q.push_back({cert_addr, cert_data});
    if (clear) begin m_dig = '0; m_acc = '0; m_drop = '0; m_ovf = 1'b0; end
    if (acc) m_dig = ref_fold(m_dig, cert_data, cert_addr[7:0]);
    if (acc && m_acc != '1) m_acc++;
    if (cert_write && !acc) begin
      m_ovf = 1'b1;
      if (m_drop != '1) m_drop++;
    end
    m_done = m_phase == 2;
    if (m_phase == 2) begin
      m_seal  = m_dig;
      m_phase = 0;
    end else if (m_phase == 1) begin
      if (hs) m_left--;
      if (m_left == 0) m_phase = 2;
    end else if (flush_req) begin
      m_left  = sz;
      m_phase = sz == 0 ? 2 : 1;
    end
  endtask
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r, input logic f, input logic c);
    cert_write = w; cert_addr = a; cert_data = d; drain_ready = r; flush_req = f; clear = c;
    model_tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask
  initial begin
    logic [31:0] x;
    logic [31:0] fa [6];
    logic [31:0] fd [6];
    int hs_cnt, rlev;
    bit seen;
    vecs[0] = '{8'h00, 32'h12345678, 32'h12345678};
`ifdef THIELE_CERT_CHAIN_EN
    vecs[1] = '{8'h5A, 32'hCAFEF00D, 32'hCAFEF057};
    vecs[2] = '{8'hFF, 32'h00000000, 32'h000000FF};
    vecs[3] = '{8'h01, 32'hFFFFFFFF, 32'hFFFFFFFE};
`else
    vecs[1] = '{8'h5A, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[2] = '{8'hFF, 32'h00000000, 32'h00000000};
    vecs[3] = '{8'h01, 32'hFFFFFFFF, 32'hFFFFFFFF};
`endif
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("reset_status", ledger_status, 32'h0);
    rst = 1'b0;
    step(1, 32'h01, 32'hDEADBEEF, 1, 0, 0);
    chk("basic_valid", 32'(drain_valid), 32'h1);
    chk("basic_data", drain_data, 32'hDEADBEEF);
    chk("basic_acc", 32'(accepted_cnt), 32'h1);
`ifdef THIELE_CERT_CHAIN_EN
    chk("basic_digest", digest, 32'hDEADBEEE);
`else
    chk("basic_digest", digest, 32'hDEADBEEF);
`endif
    step(0, 0, 0, 1, 0, 0);
    chk("basic_drained", 32'(drain_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'(vecs[i].addr), vecs[i].data, 0, 0, 1);
      chk("clear_fold", digest, vecs[i].exp);
      chk("clear_acc", 32'(accepted_cnt), 32'h1);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    x = '0;
    for (int i = 0; i < 17; i++) begin
      step(1, 32'(i), 32'hA000_0000 + 32'(i * 7), 0, 0, 0);
      if (i < 16) x = ref_fold(x, 32'hA000_0000 + 32'(i * 7), 8'(i));
    end
    chk("ovf_occ", 32'(ledger_status[15:8]), 32'd16);
    chk("ovf_dropped", 32'(dropped_cnt), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_digest", digest, x);
    step(1, 32'h99, 32'h5555_AAAA, 1, 0, 0);
    chk("ovf_no_bypass", 32'(dropped_cnt), 32'd2);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 0);
    chk("ovf_empty", 32'(drain_valid), 32'h0);
    step(0, 0, 0, 1, 1, 1);
    chk("empty_flush_seal", 32'(ledger_status[2:0]), 32'd2);
    chk("empty_flush_wait", 32'(flush_done), 32'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("empty_flush_done", 32'(flush_done), 32'd1);
    for (int i = 0; i < 6; i++) begin
      fa[i] = 32'h10 + 32'(i);
      fd[i] = 32'h3C00_0000 ^ 32'(i * 32'h01010101);
    end
    x = '0;
    for (int i = 0; i < 6; i++) x = ref_fold(x, fd[i], fa[i][7:0]);
    for (int i = 0; i < 4; i++) step(1, fa[i], fd[i], 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("flush_state", 32'(ledger_status[2:0]), 32'd1);
    hs_cnt = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (ledger_status[2:0] == 3'd1 && drain_valid) hs_cnt++;
      if (i < 2) step(1, fa[4+i], fd[4+i], 1, 0, 0);
      else step(0, 0, 0, 1, 0, 0);
      seen = flush_done;
    end
    chk("flush_seen", 32'(seen), 32'd1);
    chk("flush_handshakes", hs_cnt, 32'd4);
    chk("flush_sealed", sealed_digest, x);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'(i), 32'hBEEF_0000 + 32'(i), 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("rstflush_state", 32'(ledger_status[2:0]), 32'd1);
    rst = 1'b1;
    step(0, 0, 0, 1, 0, 0);
    rst = 1'b0;
    chk("rstflush_status", ledger_status, 32'h0);
    chk("rstflush_digest", digest, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("rstflush_no_done", 32'(flush_done), 32'd0);
    end
    rlev = 4;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) rlev = $urandom_range(0, 8);
      rst = ($urandom % 700) == 0;
      step($urandom % 4 != 0, $urandom, $urandom, ($urandom % 8) < rlev, $urandom % 16 == 0, $urandom % 64 == 0);
    end
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
